// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory port and IF/ID outputs.
// The bench or upstream logic uses master; the fetch stage uses slave.
interface if_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic             jump_taken;
  logic             terminate;
  logic [31:0]      branch_offset;
  logic [31:0]      jump_address;
  logic [31:0]      imem_data;
  logic [31:0]      imem_addr;
  logic [31:0]      instruction;
  logic [31:0]      PC;
  logic             if_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall, branch_taken, jump_taken, terminate, branch_offset, jump_address, imem_data,
    input  imem_addr, instruction, PC, if_valid, done, cycle_count, fetch_count, flush_count
  );

  modport slave (
    input  stall, branch_taken, jump_taken, terminate, branch_offset, jump_address, imem_data,
    output imem_addr, instruction, PC, if_valid, done, cycle_count, fetch_count, flush_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch plus IF/ID register: sequential fetch, decode-resolved redirects with a
// single bubble, and a fixed-length drain after terminate before raising done.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.slave bus
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  localparam logic [31:0]      DrainInit = 32'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [31:0]      pc_f_q, pc_f_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_id_q, pc_id_d;
  logic             valid_q, valid_d;
  logic [31:0]      drain_q, drain_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [31:0] seq_pc, jump_target, branch_target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Redirect targets are relative to the instruction sitting in decode, not the fetch PC.
  assign seq_pc        = pc_id_q + 32'd4;
  assign jump_target   = {seq_pc[31:28], bus.jump_address[25:0], 2'b00};
  assign branch_target = seq_pc + {bus.branch_offset[29:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    drain_d = drain_q;
    fetch_d = fetch_q;
    flush_d = flush_q;
    cyc_d   = (state_q != StDone) ? sat_inc(cyc_q) : cyc_q;

    case (state_q)
      StRun: begin
        if (bus.stall) begin
          // hold everything; redirects and terminate wait for the hazard to clear
        end else if (bus.terminate) begin
          state_d = StDrain;
          instr_d = 32'h0;
          pc_id_d = 32'h0;
          valid_d = 1'b0;
          drain_d = DrainInit;
        end else if (bus.jump_taken || bus.branch_taken) begin
          pc_f_d  = bus.jump_taken ? jump_target : branch_target;
          instr_d = 32'h0;
          pc_id_d = 32'h0;
          valid_d = 1'b0;
          flush_d = sat_inc(flush_q);
        end else begin
          instr_d = bus.imem_data;
          pc_id_d = pc_f_q;
          valid_d = 1'b1;
          pc_f_d  = pc_f_q + 32'd4;
          fetch_d = sat_inc(fetch_q);
        end
      end
      StDrain: begin
        instr_d = 32'h0;
        pc_id_d = 32'h0;
        valid_d = 1'b0;
        if (drain_q == 32'h0) state_d = StDone;
        else                  drain_d = drain_q - 32'd1;
      end
      StDone: begin
        instr_d = 32'h0;
        pc_id_d = 32'h0;
        valid_d = 1'b0;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      pc_f_q  <= RESET_PC;
      instr_q <= 32'h0;
      pc_id_q <= 32'h0;
      valid_q <= 1'b0;
      drain_q <= 32'h0;
      cyc_q   <= '0;
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      fetch_q <= fetch_d;
      flush_q <= flush_d;
    end
  end

  assign bus.imem_addr   = pc_f_q;
  assign bus.instruction = instr_q;
  assign bus.PC          = pc_id_q;
  assign bus.if_valid    = valid_q;
  assign bus.done        = (state_q == StDone);
  assign bus.cycle_count = cyc_q;
  assign bus.fetch_count = fetch_q;
  assign bus.flush_count = flush_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized control against a reference model
// that tracks architectural fetch state and the absolute edge at which done is due.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned DRAIN    = 4;
  localparam int unsigned CW       = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if #(.CNT_W(CW)) bus ();
  assign bus.imem_data = 32'h2000_0000 + bus.imem_addr;

  if_stage #(.RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   m_pc_f, m_instr, m_pc;
  logic          m_valid, m_done, m_draining;
  logic [CW-1:0] m_cyc, m_fetch, m_flush;
  int            m_edge, m_done_edge;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h2000_0000 + a;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  task automatic model_reset();
    m_pc_f = RESET_PC; m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
    m_done = 1'b0; m_draining = 1'b0; m_cyc = '0; m_fetch = '0; m_flush = '0;
    m_edge = 0; m_done_edge = 0;
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, then settle.
  task automatic step(input logic st, input logic br, input logic jp, input logic tm,
                      input logic [31:0] off, input logic [31:0] ja);
    logic [31:0] seq;
    bus.stall = st; bus.branch_taken = br; bus.jump_taken = jp; bus.terminate = tm;
    bus.branch_offset = off; bus.jump_address = ja;
    @(posedge clk);
    m_edge++;
    if (!m_done) begin
      m_cyc = sat(m_cyc);
      if (m_draining) begin
        if (m_edge == m_done_edge) m_done = 1'b1;
      end else if (st) begin
        seq = m_pc;
      end else if (tm) begin
        m_draining = 1'b1; m_done_edge = m_edge + int'(DRAIN);
        m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
      end else if (jp || br) begin
        seq = m_pc + 32'd4;
        m_pc_f = jp ? {seq[31:28], ja[25:0], 2'b00} : seq + (off << 2);
        m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
        m_flush = sat(m_flush);
      end else begin
        m_instr = imem(m_pc_f); m_pc = m_pc_f; m_valid = 1'b1;
        m_pc_f = m_pc_f + 32'd4; m_fetch = sat(m_fetch);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset imem_addr got %h want %h", bus.imem_addr, RESET_PC); end
    n_vec++; if (bus.instruction !== 32'h0) begin n_err++; $display("FAIL reset instruction got %h want 0", bus.instruction); end
    n_vec++; if (bus.PC !== 32'h0) begin n_err++; $display("FAIL reset PC got %h want 0", bus.PC); end
    n_vec++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset if_valid got %b want 0", bus.if_valid); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset done got %b want 0", bus.done); end
    n_vec++; if (bus.cycle_count !== '0 || bus.fetch_count !== '0 || bus.flush_count !== '0) begin
      n_err++; $display("FAIL reset counters got %0d/%0d/%0d want 0/0/0", bus.cycle_count, bus.fetch_count, bus.flush_count);
    end
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      n_vec++; if (bus.PC !== 32'(4*i)) begin n_err++; $display("FAIL fetch PC[%0d] got %h want %h", i, bus.PC, 32'(4*i)); end
      n_vec++; if (bus.instruction !== 32'h2000_0000 + 32'(4*i)) begin
        n_err++; $display("FAIL fetch instruction[%0d] got %h want %h", i, bus.instruction, 32'h2000_0000 + 32'(4*i));
      end
      n_vec++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL fetch if_valid[%0d] got %b want 1", i, bus.if_valid); end
    end
    n_vec++; if (bus.fetch_count !== 32'd3) begin n_err++; $display("FAIL fetch fetch_count got %0d want 3", bus.fetch_count); end
    n_vec++; if (bus.cycle_count !== 32'd3) begin n_err++; $display("FAIL fetch cycle_count got %0d want 3", bus.cycle_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      n_vec++; if (bus.PC !== 32'h8 || bus.instruction !== 32'h2000_0008) begin
        n_err++; $display("FAIL stall hold PC/instr got %h/%h want 8/20000008", bus.PC, bus.instruction);
      end
      n_vec++; if (bus.imem_addr !== 32'hC) begin n_err++; $display("FAIL stall imem_addr got %h want c", bus.imem_addr); end
      n_vec++; if (bus.fetch_count !== 32'd3) begin n_err++; $display("FAIL stall fetch_count got %0d want 3", bus.fetch_count); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== 32'hC) begin n_err++; $display("FAIL stall resume PC got %h want c", bus.PC); end
  endtask

  task automatic test_branch();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== 32'h10) begin n_err++; $display("FAIL branch setup PC got %h want 10", bus.PC); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    n_vec++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL branch imem_addr got %h want 4", bus.imem_addr); end
    n_vec++; if (bus.if_valid !== 1'b0 || bus.instruction !== 32'h0) begin
      n_err++; $display("FAIL branch bubble valid/instr got %b/%h want 0/0", bus.if_valid, bus.instruction);
    end
    n_vec++; if (bus.flush_count !== 32'd1) begin n_err++; $display("FAIL branch flush_count got %0d want 1", bus.flush_count); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== 32'h4 || bus.instruction !== 32'h2000_0004) begin
      n_err++; $display("FAIL branch target PC/instr got %h/%h want 4/20000004", bus.PC, bus.instruction);
    end
  endtask

  task automatic test_jump();
    // From PC=4, reach 0x1000_0020 with a long forward branch.
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0400_0006, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== 32'h1000_0020) begin n_err++; $display("FAIL jump setup PC got %h want 10000020", bus.PC); end
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
    n_vec++; if (bus.imem_addr !== 32'h1000_0024 || bus.PC !== 32'h1000_0020) begin
      n_err++; $display("FAIL jump under stall addr/PC got %h/%h want 10000024/10000020", bus.imem_addr, bus.PC);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h40);
    n_vec++; if (bus.imem_addr !== 32'h1000_0100) begin n_err++; $display("FAIL jump priority imem_addr got %h want 10000100", bus.imem_addr); end
    n_vec++; if (bus.flush_count !== 32'd3) begin n_err++; $display("FAIL jump flush_count got %0d want 3", bus.flush_count); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== 32'h1000_0100) begin n_err++; $display("FAIL jump target PC got %h want 10000100", bus.PC); end
  endtask

  task automatic test_random();
    logic st, br, jp;
    logic [31:0] off, ja;
    for (int i = 0; i < 300; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      jp  = ($urandom_range(0, 15) == 0);
      off = 32'($urandom_range(0, 64)) - 32'd32;
      ja  = $urandom;
      step(st, br, jp, 1'b0, off, ja);
      n_vec++; if (bus.imem_addr !== m_pc_f) begin n_err++; $display("FAIL random imem_addr[%0d] got %h want %h", i, bus.imem_addr, m_pc_f); end
      n_vec++; if (bus.instruction !== m_instr || bus.PC !== m_pc || bus.if_valid !== m_valid) begin
        n_err++; $display("FAIL random ifid[%0d] got %h/%h/%b want %h/%h/%b", i, bus.instruction, bus.PC, bus.if_valid, m_instr, m_pc, m_valid);
      end
      n_vec++; if (bus.fetch_count !== m_fetch || bus.flush_count !== m_flush || bus.cycle_count !== m_cyc) begin
        n_err++; $display("FAIL random counters[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, bus.fetch_count, bus.flush_count, bus.cycle_count, m_fetch, m_flush, m_cyc);
      end
    end
  endtask

  task automatic test_terminate();
    logic [CW-1:0] c0;
    logic [31:0]   a0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7, 32'h123);
    c0 = m_cyc;
    a0 = m_pc_f;
    for (int k = 1; k <= 8; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom);
      n_vec++; if (bus.done !== (k >= int'(DRAIN))) begin n_err++; $display("FAIL terminate done[k=%0d] got %b want %b", k, bus.done, (k >= int'(DRAIN))); end
      n_vec++; if (bus.instruction !== 32'h0 || bus.if_valid !== 1'b0) begin
        n_err++; $display("FAIL terminate ifid[k=%0d] got %h/%b want 0/0", k, bus.instruction, bus.if_valid);
      end
      n_vec++; if (bus.imem_addr !== a0) begin n_err++; $display("FAIL terminate imem_addr[k=%0d] got %h want %h", k, bus.imem_addr, a0); end
      n_vec++; if (bus.cycle_count !== c0 + CW'((k < int'(DRAIN)) ? k : int'(DRAIN))) begin
        n_err++; $display("FAIL terminate cycle_count[k=%0d] got %0d want %0d", k, bus.cycle_count, c0 + CW'((k < int'(DRAIN)) ? k : int'(DRAIN)));
      end
      n_vec++; if (bus.done !== m_done) begin n_err++; $display("FAIL terminate model done[k=%0d] got %b want %b", k, bus.done, m_done); end
    end
  endtask

  task automatic test_reset_in_drain();
    #2; rst = 1'b0; #1;
    @(negedge clk); rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2; rst = 1'b0; #1;
    n_vec++; if (bus.imem_addr !== RESET_PC) begin n_err++; $display("FAIL drain reset imem_addr got %h want %h", bus.imem_addr, RESET_PC); end
    n_vec++; if (bus.cycle_count !== '0 || bus.fetch_count !== '0 || bus.flush_count !== '0) begin
      n_err++; $display("FAIL drain reset counters got %0d/%0d/%0d want 0/0/0", bus.cycle_count, bus.fetch_count, bus.flush_count);
    end
    n_vec++; if (bus.done !== 1'b0 || bus.if_valid !== 1'b0 || bus.PC !== 32'h0) begin
      n_err++; $display("FAIL drain reset done/valid/PC got %b/%b/%h want 0/0/0", bus.done, bus.if_valid, bus.PC);
    end
    @(negedge clk); rst = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_vec++; if (bus.PC !== RESET_PC || bus.instruction !== imem(RESET_PC)) begin
      n_err++; $display("FAIL drain restart PC/instr got %h/%h want %h/%h", bus.PC, bus.instruction, RESET_PC, imem(RESET_PC));
    end
    n_vec++; if (bus.fetch_count !== 32'd1) begin n_err++; $display("FAIL drain restart fetch_count got %0d want 1", bus.fetch_count); end
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump_taken = 1'b0; bus.terminate = 1'b0;
    bus.branch_offset = 32'h0; bus.jump_address = 32'h0;
    model_reset();
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_jump();
    test_random();
    test_terminate();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
